// File: rtl/tx_intf_pkg.sv
// Shared definitions for the TX interface packet scheduler: FSM states and
// descriptor field positions.
package tx_intf_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      POP      = 3'd1,
      WAIT_TSF = 3'd2,
      CTS      = 3'd3,
      STREAM   = 3'd4,
      GAP      = 3'd5
   } sched_state_t;

   localparam int CTS_EN_BIT    = 63;
   localparam int CTS_CFG_MSB   = 62;
   localparam int CTS_CFG_LSB   = 32;
   localparam int CTS_CFG_WIDTH = CTS_CFG_MSB - CTS_CFG_LSB + 1;

endpackage

// File: rtl/tx_intf_tsf_cmp.sv
// Launch-time comparator: holds the popped launch TSF and produces a registered
// go flag every compare cycle, plus a one-shot late flag on the first compare.
module tx_intf_tsf_cmp #(
   parameter int TSF_TIMER_WIDTH = 64
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       load,
   input  logic [TSF_TIMER_WIDTH-1:0] load_tsf,
   input  logic                       cmp_en,
   input  logic [TSF_TIMER_WIDTH-1:0] tsf_runtime_val,
   output logic                       go,
   output logic                       late
);

   logic [TSF_TIMER_WIDTH-1:0] launch_tsf;
   logic                       first_cmp;

   // NOTE: sequential state uses non-blocking assignments only, and the flags
   // default low every cycle so they can only ever be one-cycle results.
   always_ff @(posedge CLK) begin
      if (RST) begin
         launch_tsf <= '0;
         first_cmp  <= 1'b0;
         go         <= 1'b0;
         late       <= 1'b0;
      end else begin
         go   <= 1'b0;
         late <= 1'b0;
         if (load) begin
            launch_tsf <= load_tsf;
            first_cmp  <= 1'b1;
         end else if (cmp_en) begin
            first_cmp <= 1'b0;
            go        <= (launch_tsf == '0) || (tsf_runtime_val >= launch_tsf);
            late      <= first_cmp && (launch_tsf != '0) && (tsf_runtime_val > launch_tsf);
         end
      end
   end

endmodule

// File: rtl/tx_intf_pkt_sched.sv
// TX packet scheduler: pops a descriptor and launch TSF, waits for launch time,
// optionally requests CTS-to-self, then streams the packet's data words.
module tx_intf_pkt_sched
   import tx_intf_pkg::*;
#(
   parameter int C_DATA_WIDTH           = 64,
   parameter int TSF_TIMER_WIDTH        = 64,
   parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
   parameter int GAP_CYCLES             = 16,
   parameter int UNDERRUN_LIMIT         = 1023
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       sched_en,
   input  logic                       dmg_empty,
   input  logic [C_DATA_WIDTH-1:0]    dmg_data,
   output logic                       dmg_rden,
   input  logic                       tsf_empty,
   input  logic [TSF_TIMER_WIDTH-1:0] tsf_data,
   output logic                       tsf_rden,
   input  logic                       data_empty,
   input  logic [C_DATA_WIDTH-1:0]    data_in,
   output logic                       data_rden,
   input  logic [TSF_TIMER_WIDTH-1:0] tsf_runtime_val,
   output logic                       cts_req,
   output logic [CTS_CFG_WIDTH-1:0]   cts_cfg,
   input  logic                       cts_done,
   output logic [C_DATA_WIDTH-1:0]    m_data,
   output logic                       m_valid,
   output logic                       m_last,
   input  logic                       m_ready,
   output logic                       busy,
   output logic                       pkt_done,
   output logic                       late_launch,
   output logic                       underrun_err,
   output logic [15:0]                pkt_cnt
);

   localparam int UR_W  = $clog2(UNDERRUN_LIMIT + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int WC_W  = MAX_BIT_NUM_DMA_SYMBOL;

   sched_state_t    state;
   logic [WC_W-1:0] words_m1;
   logic [WC_W-1:0] word_cnt;
   logic            cts_en;
   logic [UR_W-1:0] empty_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic            tsf_go;
   logic            stream_end;
   logic            stream_abort;
   logic            unused_dmg_bits;

   assign unused_dmg_bits = ^dmg_data[CTS_CFG_LSB-1:WC_W];

   tx_intf_tsf_cmp #(
      .TSF_TIMER_WIDTH (TSF_TIMER_WIDTH)
   ) u_tsf_cmp (
      .CLK             (CLK),
      .RST             (RST),
      .load            (state == POP),
      .load_tsf        (tsf_data),
      .cmp_en          (state == WAIT_TSF),
      .tsf_runtime_val (tsf_runtime_val),
      .go              (tsf_go),
      .late            (late_launch)
   );

   // Stream side is driven straight from the FWFT head; m_ready only feeds the pop.
   assign busy      = (state != IDLE);
   assign dmg_rden  = (state == POP);
   assign tsf_rden  = (state == POP);
   assign m_valid   = (state == STREAM) & ~data_empty;
   assign m_data    = (state == STREAM) ? data_in : '0;
   assign m_last    = m_valid & (word_cnt == words_m1);
   assign data_rden = m_valid & m_ready;

   assign stream_end   = data_rden & m_last;
   assign stream_abort = (state == STREAM) & data_empty & (empty_cnt == UR_W'(UNDERRUN_LIMIT - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         words_m1     <= '0;
         word_cnt     <= '0;
         cts_en       <= 1'b0;
         cts_cfg      <= '0;
         empty_cnt    <= '0;
         gap_cnt      <= '0;
         cts_req      <= 1'b0;
         pkt_done     <= 1'b0;
         underrun_err <= 1'b0;
         pkt_cnt      <= '0;
      end else begin
         cts_req      <= 1'b0;
         pkt_done     <= 1'b0;
         underrun_err <= 1'b0;
         case (state)
            IDLE: begin
               if (sched_en && !dmg_empty && !tsf_empty) state <= POP;
            end
            POP: begin
               words_m1 <= dmg_data[WC_W-1:0];
               cts_en   <= dmg_data[CTS_EN_BIT];
               cts_cfg  <= dmg_data[CTS_CFG_MSB:CTS_CFG_LSB];
               state    <= WAIT_TSF;
            end
            WAIT_TSF: begin
               if (tsf_go) begin
                  word_cnt  <= '0;
                  empty_cnt <= '0;
                  if (cts_en) begin
                     cts_req <= 1'b1;
                     state   <= CTS;
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            CTS: begin
               if (cts_done) state <= STREAM;
            end
            STREAM: begin
               if (stream_end || stream_abort) begin
                  state        <= GAP;
                  gap_cnt      <= '0;
                  cts_cfg      <= '0;
                  pkt_done     <= 1'b1;
                  underrun_err <= stream_abort;
                  pkt_cnt      <= pkt_cnt + 16'd1;
               end else if (data_rden) begin
                  empty_cnt <= '0;
                  word_cnt  <= word_cnt + WC_W'(1);
               end else if (data_empty) begin
                  empty_cnt <= empty_cnt + UR_W'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
